// File: rtl/acc32_pipe_if.sv
// Operand/result bundle for acc32_pipe. The master drives the operand side and the
// slave (the accumulator) drives the result side.
interface acc32_pipe_if #(parameter int DW = 16);
  // Operand handshake: an operand is taken on any rising edge with CE=1 and IN_VALID=1.
  // There is no backpressure. OUT_VALID marks the single cycle in which Q/OVF reflect
  // a newly completed operand.
  logic            CE;
  logic            IN_VALID;
  logic            LOAD;
  logic            SUB;
  logic [DW-1:0]   D;
  logic [2*DW-1:0] Q;
  logic            OUT_VALID;
  logic            OVF;

  modport master (output CE, IN_VALID, LOAD, SUB, D, input Q, OUT_VALID, OVF);
  modport slave  (input CE, IN_VALID, LOAD, SUB, D, output Q, OUT_VALID, OVF);
endinterface

// File: rtl/acc32_pipe.sv
// Two-stage 2*DW-bit signed accumulator: stage 1 adds the low half, stage 2 the high half
// with the registered carry. Define ACC_OVF_STICKY_EN to make OVF sticky until a LOAD.
module acc32_pipe #(
  parameter int DW = 16
) (
  input logic        CLK,
  input logic        RST,
  acc32_pipe_if.slave bus
);

  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo_q;
  logic [DW-1:0] r_e;
  logic          r_c1;
  logic          r_ld1;
  logic          r_v1;
  logic          r_v2;
  logic          r_ovf;

  logic [DW-1:0] w_x;
  logic [DW:0]   w_s1;
  logic [DW-1:0] w_hi_base;
  logic [DW-1:0] w_hi_new;
  logic          w_ovf_now;
  logic          w_ovf_next;

  // Subtraction is ~D plus a carry-in of 1, so both stages see only additions.
  assign w_x       = bus.SUB ? ~bus.D : bus.D;
  assign w_s1      = {1'b0, (bus.LOAD ? {DW{1'b0}} : r_lo)} + {1'b0, w_x}
                   + {{DW{1'b0}}, bus.SUB};
  assign w_hi_base = r_ld1 ? {DW{1'b0}} : r_hi;
  assign w_hi_new  = w_hi_base + r_e + {{(DW-1){1'b0}}, r_c1};

  // Overflow: operand and old total share a sign, and the new total's sign differs.
  assign w_ovf_now = ~r_ld1 & (r_hi[DW-1] == r_e[DW-1]) & (w_hi_new[DW-1] != r_hi[DW-1]);

`ifdef ACC_OVF_STICKY_EN
  assign w_ovf_next = (r_ovf & ~r_ld1) | w_ovf_now;
`else
  assign w_ovf_next = w_ovf_now;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_lo_q <= '0;
      r_e    <= '0;
      r_c1   <= 1'b0;
      r_ld1  <= 1'b0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.CE) begin
      if (bus.IN_VALID) begin
        r_lo  <= w_s1[DW-1:0];
        r_c1  <= w_s1[DW];
        r_e   <= {DW{w_x[DW-1]}};
        r_ld1 <= bus.LOAD;
        r_v1  <= 1'b1;
      end else begin
        r_v1  <= 1'b0;
      end

      if (r_v1) begin
        r_hi   <= w_hi_new;
        r_lo_q <= r_lo;
        r_ovf  <= w_ovf_next;
        r_v2   <= 1'b1;
      end else begin
        r_v2   <= 1'b0;
      end
    end
  end

  assign bus.Q         = {r_hi, r_lo_q};
  assign bus.OUT_VALID = r_v2;
  assign bus.OVF       = r_ovf;

endmodule

// File: tb/tb_acc32_pipe.sv
// Directed bench for acc32_pipe: an arithmetic reference model checked every cycle,
// plus literal expectations from hand-worked sequences.
module tb_acc32_pipe;

  logic clk;
  logic rst;
  acc32_pipe_if #(.DW(16)) bus ();

  acc32_pipe #(.DW(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Running total in plain integer arithmetic; each accepted operand's result is due at
  // the next CE-enabled edge after the one that accepted it.
  logic [32:0]        exp_q[$];   // {ovf, q}
  int                 due_q[$];
  logic signed [31:0] m_tot = '0;
  logic               m_ovf = 1'b0;
  int                 ce_cnt = 0;
  bit                 last_ce = 0;
  logic [31:0]        held_q = '0;
  logic               held_ovf = 1'b0;
  logic               held_ov = 1'b0;

  always @(posedge clk) begin
    longint val;
    longint sum;
    logic   ovf_now;
    if (!rst && bus.CE) begin
      ce_cnt++;
      last_ce = 1;
      if (bus.IN_VALID) begin
        val = longint'($signed(bus.D));
        if (bus.SUB) val = -val;
        sum = (bus.LOAD ? 64'sd0 : longint'(m_tot)) + val;
        ovf_now = !bus.LOAD && (sum > 64'sd2147483647 || sum < -64'sd2147483648);
        m_tot = sum[31:0];
`ifdef ACC_OVF_STICKY_EN
        m_ovf = bus.LOAD ? 1'b0 : (m_ovf | ovf_now);
`else
        m_ovf = ovf_now;
`endif
        exp_q.push_back({m_ovf, m_tot});
        due_q.push_back(ce_cnt + 1);
      end
    end else begin
      last_ce = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_tot = '0;
      m_ovf = 1'b0;
      held_q = '0;
      held_ovf = 1'b0;
      held_ov = 1'b0;
    end else if (last_ce) begin
      held_ov = (due_q.size() > 0) && (due_q[0] == ce_cnt);
      if (held_ov) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        held_q   = e[31:0];
        held_ovf = e[32];
      end
    end
    check("model_out_valid", 64'(bus.OUT_VALID), 64'(held_ov));
    check("model_q",         64'(bus.Q),         64'(held_q));
    check("model_ovf",       64'(bus.OVF),       64'(held_ovf));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ce, input logic iv, input logic ld, input logic sb,
                       input logic [15:0] d);
    @(posedge clk);
    #1;
    bus.CE = ce; bus.IN_VALID = iv; bus.LOAD = ld; bus.SUB = sb; bus.D = d;
  endtask

  task automatic op(input logic ld, input logic sb, input logic [15:0] d);
    drive(1'b1, 1'b1, ld, sb, d);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic freeze();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic expect_out(input string name, input logic ov, input logic [31:0] q,
                            input logic ovf);
    check({name, "_ov"},  64'(bus.OUT_VALID), 64'(ov));
    check({name, "_q"},   64'(bus.Q),         64'(q));
    check({name, "_ovf"}, 64'(bus.OVF),       64'(ovf));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.CE = 1'b0; bus.IN_VALID = 1'b0; bus.LOAD = 1'b0; bus.SUB = 1'b0; bus.D = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 32'h0000_0000, 1'b0);
    rst = 1'b0;
    idle();

    // Reset mid-stream: LOAD 1 sits in stage 1, ADD 2 is presented but never taken.
    op(1'b1, 1'b0, 16'h0001);
    op(1'b0, 1'b0, 16'h0002);
    #3 rst = 1'b1;
    #1 expect_out("rst_flush", 1'b0, 32'h0000_0000, 1'b0);
    idle();
    idle();
    rst = 1'b0;
    idle();
    expect_out("rst_after1", 1'b0, 32'h0000_0000, 1'b0);
    idle();
    expect_out("rst_after2", 1'b0, 32'h0000_0000, 1'b0);

    // Cross-half carry.
    op(1'b1, 1'b0, 16'hFFFF);
    op(1'b0, 1'b0, 16'h0001);
    idle();
    expect_out("carry_load", 1'b1, 32'hFFFF_FFFF, 1'b0);
    idle();
    expect_out("carry_wrap", 1'b1, 32'h0000_0000, 1'b0);

    // Subtract.
    op(1'b1, 1'b0, 16'h0005);
    op(1'b0, 1'b1, 16'h0007);
    idle();
    expect_out("sub_load", 1'b1, 32'h0000_0005, 1'b0);
    idle();
    expect_out("sub_res", 1'b1, 32'hFFFF_FFFE, 1'b0);
    idle();
    expect_out("sub_end", 1'b0, 32'hFFFF_FFFE, 1'b0);

    // Streaming with a gap.
    op(1'b1, 1'b0, 16'h0010);
    op(1'b0, 1'b0, 16'h0020);
    idle();
    expect_out("strm_0", 1'b1, 32'h0000_0010, 1'b0);
    op(1'b0, 1'b0, 16'h7FFF);
    expect_out("strm_1", 1'b1, 32'h0000_0030, 1'b0);
    idle();
    expect_out("strm_gap", 1'b0, 32'h0000_0030, 1'b0);
    idle();
    expect_out("strm_2", 1'b1, 32'h0000_802F, 1'b0);

    // CE freeze with one operand in stage 1.
    op(1'b1, 1'b0, 16'h1234);
    freeze();
    expect_out("frz_a", 1'b0, 32'h0000_802F, 1'b0);
    freeze();
    expect_out("frz_b", 1'b0, 32'h0000_802F, 1'b0);
    freeze();
    expect_out("frz_c", 1'b0, 32'h0000_802F, 1'b0);
    idle();
    expect_out("frz_d", 1'b0, 32'h0000_802F, 1'b0);
    idle();
    expect_out("frz_res", 1'b1, 32'h0000_1234, 1'b0);
    idle();

    // Overflow: LOAD 0x7FFF then 65538 adds of 0x7FFF.
    op(1'b1, 1'b0, 16'h7FFF);
    for (int i = 0; i < 65538; i++) op(1'b0, 1'b0, 16'h7FFF);
    op(1'b0, 1'b0, 16'h0000);
    idle();
    expect_out("ovf_hit", 1'b1, 32'h8000_7FFD, 1'b1);
    idle();
`ifdef ACC_OVF_STICKY_EN
    expect_out("ovf_next", 1'b1, 32'h8000_7FFD, 1'b1);
`else
    expect_out("ovf_next", 1'b1, 32'h8000_7FFD, 1'b0);
`endif
    op(1'b1, 1'b0, 16'h0000);
    idle();
    idle();
    expect_out("ovf_clear", 1'b1, 32'h0000_0000, 1'b0);
    idle();
    idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
